mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory bus controller directly downstream of the ALU in APCPU.
//  Accepts ALU memory requests (MemIO/ALUAddr/DataIO), runs one single-word
//  read or write on the external memory port with wait-state and timeout
//  handling, and returns completion to the ALU via ValidMemData, plus read
//  data on the shared DataIO bus. 4-phase handshake: ALU holds MemIO until
//  it sees ValidMemData, then drops MemIO to 00.
// PARAMETERS
//  DATA_W   32  width of DataIO / memory data
//  ADDR_W   32  width of ALUAddr / MemAddr (word address)
//  TIMEOUT  16  max ACCESS cycles without MemReady before bus error (>=1)
// PORTS
//  clk           in     1       system clock, rising edge
//  rst_n         in     1       asynchronous active-low reset
//  MemIO         in     2       ALU request: 00 idle, 01 read, 10 write, 11 reserved
//  ALUAddr       in     ADDR_W  request address
//  DataIO        inout  DATA_W  ALU data bus: ALU drives on write, ctrl drives on read done
//  ValidMemData  out    1       request complete (read data valid / write acked)
//  BusError      out    1       timeout or reserved MemIO code
//  MemAddr       out    ADDR_W  external address
//  MemWData      out    DATA_W  external write data
//  MemRE         out    1       external read strobe
//  MemWE         out    1       external write strobe
//  MemRData      in     DATA_W  external read data
//  MemReady      in     1       external access complete this cycle
// BEHAVIOUR
//  - Clock clk; reset asynchronous, active-low (rst_n). Reset: state IDLE, all
//    outputs 0, DataIO high-Z, wait counter 0. Mid-access reset drops strobes
//    immediately; the bus cycle is abandoned.
//  - FSM states: IDLE, ACCESS, DONE, ERR.
//  - IDLE: MemIO=01/10 at edge N -> latch ALUAddr, op, DataIO (write) ->
//    ACCESS. MemIO=11 -> ERR. MemIO=00 -> stay.
//  - ACCESS: MemAddr=latched addr; MemRE (read) or MemWE (write) held high;
//    MemWData=latched data. Edge with MemReady=1 -> capture MemRData (read),
//    strobes low, -> DONE. Otherwise count++; reaching TIMEOUT without ready
//    -> ERR. MemReady and last-count in the same cycle: ready wins.
//  - Min latency: request sampled edge N, strobe in cycle N..N+1, MemReady=1
//    at edge N+1 -> ValidMemData=1 after edge N+1.
//  - DONE: ValidMemData=1; on read, DataIO driven with captured data, else
//    high-Z. Held until MemIO=00 is sampled -> IDLE (ValidMemData low and
//    DataIO released the same edge).
//  - ERR: BusError=1, ValidMemData=0, DataIO high-Z; MemIO=00 sampled -> IDLE.
//  - MemIO/ALUAddr/DataIO changes during ACCESS are ignored (latched values
//    used). MemIO=00 during ACCESS: bus cycle still completes, then DONE
//    sees 00 -> one-cycle ValidMemData, then IDLE.
//  - Counter saturates; it is cleared on every entry to ACCESS.
//  - DataIO is never driven by the controller except in DONE with a read op.
// STRUCTURE
//  - Package apcpu_mem_pkg: MemIO codes (MIO_IDLE/READ/WRITE/RSVD), FSM
//    state encoding, default TIMEOUT.
//  - One sub-module: mem_wait_timer (clear/enable/expired, width
//    $clog2(TIMEOUT+1)); rest is flat FSM + datapath latches.
// TESTING
//  - Read, MemReady high one cycle after strobe, MemRData=32'hDEADBEEF,
//    ALUAddr=250 -> MemAddr=250, MemRE 1 cycle, ValidMemData=1 and
//    DataIO=32'hDEADBEEF until MemIO=00, then high-Z.
//  - Write ALUAddr=124802, DataIO=199, MemReady after 3 waits -> MemWE high
//    4 cycles, MemWData=199, ValidMemData=1, DataIO never driven by ctrl.
//  - No MemReady, TIMEOUT=16 -> strobe exactly 16 cycles, BusError=1, held
//    until MemIO=00, ValidMemData stays 0.
//  - MemIO=11 in IDLE -> BusError next cycle, no strobes; clears on MemIO=00.
//  - MemReady on the 16th (last) ACCESS cycle -> DONE, no BusError.
//  - rst_n low mid-ACCESS -> MemRE/MemWE/ValidMemData 0 and DataIO high-Z
//    without waiting for clk; next read completes normally.

Source files
------------

// File: rtl/apcpu_mem_pkg.sv
// Shared definitions for the APCPU memory access controller: request codes,
// FSM state encoding and default sizing.
package apcpu_mem_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        MIO_IDLE  = 2'b00,
        MIO_READ  = 2'b01,
        MIO_WRITE = 2'b10,
        MIO_RSVD  = 2'b11
    } mem_io_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_ERR    = 2'b11
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// ALU request/response handshake plus the external memory port.
// The shared DataIO bus is tristate and is kept as a plain port of the top.
interface mem_access_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic [1:0]        MemIO;
    logic [ADDR_W-1:0] ALUAddr;
    logic              ValidMemData;
    logic              BusError;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemRE;
    logic              MemWE;
    logic [DATA_W-1:0] MemRData;
    logic              MemReady;

    modport slave (
        input  MemIO, ALUAddr, MemRData, MemReady,
        output ValidMemData, BusError, MemAddr, MemWData, MemRE, MemWE
    );

    modport master (
        output MemIO, ALUAddr, MemRData, MemReady,
        input  ValidMemData, BusError, MemAddr, MemWData, MemRE, MemWE
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait-state counter; expired_c flags the last permitted ACCESS cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q < CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-word memory bus controller between the ALU and external memory,
// with wait states, timeout-to-bus-error and a 4-phase completion handshake.
module mem_access_ctrl
    import apcpu_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus,
    inout  wire [DATA_W-1:0]  DataIO
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              op_wr_q, op_wr_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              drive_q, drive_d;

    mem_io_e mem_io;
    logic    timer_clr;
    logic    timer_en;
    logic    timer_last;

    assign mem_io    = mem_io_e'(bus.MemIO);
    assign timer_clr = (state_q != ST_ACCESS);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clr),
        .enable    (timer_en),
        .expired_c (timer_last)
    );

    // Next state and latched datapath; outputs are decoded from the next state
    // so every output is a flop.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        op_wr_d  = op_wr_q;
        timer_en = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                unique case (mem_io)
                    MIO_READ, MIO_WRITE: begin
                        state_d = ST_ACCESS;
                        addr_d  = bus.ALUAddr;
                        op_wr_d = (mem_io == MIO_WRITE);
                        if (mem_io == MIO_WRITE) begin
                            wdata_d = DataIO;
                        end
                    end
                    MIO_RSVD: state_d = ST_ERR;
                    default:  state_d = ST_IDLE;
                endcase
            end
            ST_ACCESS: begin
                // Ready on the last permitted cycle still completes the access.
                if (bus.MemReady) begin
                    state_d = ST_DONE;
                    if (!op_wr_q) begin
                        rdata_d = bus.MemRData;
                    end
                end else if (timer_last) begin
                    state_d = ST_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DONE, ST_ERR: begin
                if (mem_io == MIO_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        re_d    = (state_d == ST_ACCESS) && !op_wr_d;
        we_d    = (state_d == ST_ACCESS) && op_wr_d;
        valid_d = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERR);
        drive_d = (state_d == ST_DONE) && !op_wr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_wr_q <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_wr_q <= op_wr_d;
            re_q    <= re_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drive_q <= drive_d;
        end
    end

    assign bus.MemAddr      = addr_q;
    assign bus.MemWData     = wdata_q;
    assign bus.MemRE        = re_q;
    assign bus.MemWE        = we_q;
    assign bus.ValidMemData = valid_q;
    assign bus.BusError     = err_q;

    assign DataIO = drive_q ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: the stimulus pushes the
// outcome predicted from the access rules, an independent monitor checks it.
module tb_mem_access_ctrl;
    import apcpu_mem_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 16;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          valid;
        bit          err;
        int          strobes;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    logic alu_oe;
    logic [DW-1:0] alu_wdata;
    wire  [DW-1:0] data_io;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur;
    bit   prev_done;
    int   strobe_cnt;

    mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_access_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .DataIO (data_io)
    );

    assign data_io = alu_oe ? alu_wdata : {DW{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_released(input logic [DW-1:0] v);
        return (v === {DW{1'bz}}) || (v === {DW{1'b0}});
    endfunction

    // Reference outcome computed from the access rules alone.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int waits);
        exp_t e;
        e.is_wr = (op == MIO_WRITE);
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = rdata;
        if (op == MIO_RSVD) begin
            e.valid = 0; e.err = 1; e.strobes = 0; e.lat = 0;
        end else if (waits < int'(TMO)) begin
            e.valid = 1; e.err = 0; e.strobes = waits + 1; e.lat = waits + 1;
        end else begin
            e.valid = 0; e.err = 1; e.strobes = int'(TMO); e.lat = int'(TMO);
        end
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        bit done_now;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            strobe_cnt = 0;
            prev_done  = 0;
            have_cur   = 0;
        end else begin
            done_now = bus.ValidMemData || bus.BusError;
            if (bus.MemRE || bus.MemWE) begin
                strobe_cnt++;
                if (sb.size() > 0) begin
                    check("strobe_re", 64'(bus.MemRE), 64'(!sb[0].is_wr));
                    check("strobe_we", 64'(bus.MemWE), 64'(sb[0].is_wr));
                    check("mem_addr", 64'(bus.MemAddr), 64'(sb[0].addr));
                    if (sb[0].is_wr) check("mem_wdata", 64'(bus.MemWData), 64'(sb[0].wdata));
                end
            end
            if (done_now && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 64'(done_now), 64'(0));
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1;
                    check("valid_kind", 64'(bus.ValidMemData), 64'(cur.valid));
                    check("err_kind", 64'(bus.BusError), 64'(cur.err));
                    check("strobe_cycles", 64'(strobe_cnt), 64'(cur.strobes));
                end
                strobe_cnt = 0;
            end
            if (bus.ValidMemData && bus.BusError) check("valid_and_err", 64'(1), 64'(0));
            if (bus.ValidMemData && have_cur && !cur.is_wr)
                check("read_data_io", 64'(data_io), 64'(cur.rdata));
            else if (!alu_oe)
                check("data_io_released", 64'(is_released(data_io)), 64'(1));
            prev_done = done_now;
        end
    end

    task automatic do_txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits, input int hold,
                          input bit early_drop);
        exp_t e;
        int lat;
        @(negedge clk);
        bus.MemIO    = op;
        bus.ALUAddr  = addr;
        alu_wdata    = wdata;
        alu_oe       = (op == MIO_WRITE);
        bus.MemReady = 1'b0;
        e = model(op, addr, wdata, rdata, waits);
        sb.push_back(e);
        @(negedge clk);
        if (early_drop) bus.MemIO = MIO_IDLE;
        bus.ALUAddr = $urandom;
        alu_wdata   = $urandom;
        lat = 0;
        while (!(bus.ValidMemData || bus.BusError) && lat < int'(TMO) + 4) begin
            bus.MemReady = (lat == waits);
            bus.MemRData = (lat == waits) ? rdata : $urandom;
            @(negedge clk);
            lat++;
        end
        bus.MemReady = 1'b0;
        alu_oe = 1'b0;
        check("latency", 64'(lat), 64'(e.lat));
        if (!early_drop) begin
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", 64'(bus.ValidMemData), 64'(e.valid));
                check("hold_err", 64'(bus.BusError), 64'(e.err));
            end
            bus.MemIO = MIO_IDLE;
        end
        @(negedge clk);
        check("release_valid", 64'(bus.ValidMemData), 64'(0));
        check("release_err", 64'(bus.BusError), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_re"}, 64'(bus.MemRE), 64'(0));
        check({tag, "_we"}, 64'(bus.MemWE), 64'(0));
        check({tag, "_valid"}, 64'(bus.ValidMemData), 64'(0));
        check({tag, "_err"}, 64'(bus.BusError), 64'(0));
        check({tag, "_data_io"}, 64'(is_released(data_io)), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        alu_oe = 1'b0;
        alu_wdata = '0;
        bus.MemIO = MIO_IDLE;
        bus.ALUAddr = '0;
        bus.MemRData = '0;
        bus.MemReady = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("reset_addr", 64'(bus.MemAddr), 64'(0));
        check("reset_wdata", 64'(bus.MemWData), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_txn(MIO_READ, 32'd250, 32'd0, 32'hDEADBEEF, 0, 2, 0);
        do_txn(MIO_WRITE, 32'd124802, 32'd199, 32'd0, 3, 1, 0);
        do_txn(MIO_READ, 32'h0000_1234, 32'd0, 32'h5555_AAAA, 1000, 2, 0);
        do_txn(MIO_RSVD, 32'h0000_0040, 32'd0, 32'd0, 0, 1, 0);
        do_txn(MIO_WRITE, 32'h0000_0777, 32'hCAFE_F00D, 32'd0, int'(TMO) - 1, 0, 0);
        do_txn(MIO_READ, 32'h0000_0888, 32'd0, 32'h1357_9BDF, 2, 0, 1);

        // Reset while a read is waiting on memory.
        @(negedge clk);
        bus.MemIO = MIO_READ;
        bus.ALUAddr = 32'h0000_0999;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_access");
        bus.MemIO = MIO_IDLE;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_txn(MIO_READ, 32'h0000_0ABC, 32'd0, 32'h2468_ACE0, 1, 1, 0);

        // Reset while read data is being driven back to the ALU.
        @(negedge clk);
        bus.MemIO = MIO_READ;
        bus.ALUAddr = 32'h0000_0DEF;
        sb.push_back(model(MIO_READ, 32'h0000_0DEF, 32'd0, 32'h0F0F_F0F0, 0));
        @(negedge clk);
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h0F0F_F0F0;
        @(negedge clk);
        bus.MemReady = 1'b0;
        check("pre_rst_valid", 64'(bus.ValidMemData), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_done");
        bus.MemIO = MIO_IDLE;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 40; n++) begin
            int r;
            logic [1:0] op;
            r  = int'($urandom_range(0, 9));
            op = (r == 0) ? MIO_RSVD : (r < 5) ? MIO_READ : MIO_WRITE;
            do_txn(op, $urandom, $urandom, $urandom, int'($urandom_range(0, 19)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
